// File: rtl/vga_pkg.sv
// VGA 640x480@60 timing constants and game-step rate table.
// Shared by vga_timing_gen and vga_sync.
package vga_pkg;

    localparam int H_DISP  = 640;
    localparam int H_FP    = 16;
    localparam int H_SYNC  = 96;
    localparam int H_BP    = 48;
    localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;

    localparam int V_DISP  = 480;
    localparam int V_FP    = 10;
    localparam int V_SYNC  = 2;
    localparam int V_BP    = 33;
    localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

    localparam int CLK_DIV_DEF = 2;

    typedef enum logic [1:0] {
        SPD_30 = 2'b00,
        SPD_15 = 2'b01,
        SPD_8  = 2'b10,
        SPD_4  = 2'b11
    } speed_t;

    // Frames per game step for a given speed select.
    function automatic logic [4:0] speed_period(input logic [1:0] sel);
        logic [4:0] p;
        p = 5'd30;
        unique case (sel)
            SPD_30: p = 5'd30;
            SPD_15: p = 5'd15;
            SPD_8:  p = 5'd8;
            SPD_4:  p = 5'd4;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/vga_pix_div.sv
// Pixel-rate divider: one-clock pix_tick every CLK_DIV system clocks.
// CLK_DIV=1 leaves the counter at zero and the tick permanently high.
module vga_pix_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic pix_tick
);

    localparam logic [3:0] DIV_MAX = 4'(CLK_DIV - 1);

    logic [3:0] div_cnt;

    // Free-running modulo-CLK_DIV counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_MAX) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 4'd1;
        end
    end

    assign pix_tick = (div_cnt == DIV_MAX);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster counters plus frame-based game-step tick generator.
// Pulses are compares of registered state; inputs are registered first.
module vga_timing_gen #(
    parameter int CLK_DIV = vga_pkg::CLK_DIV_DEF,
    parameter int H_TOTAL = vga_pkg::H_TOTAL,
    parameter int V_TOTAL = vga_pkg::V_TOTAL
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] speed_sel,
    input  logic       pause,
    output logic       pix_tick,
    output logic [9:0] h_count,
    output logic [9:0] v_count,
    output logic       line_end,
    output logic       frame_end,
    output logic       game_tick
);

    import vga_pkg::*;

    localparam logic [9:0] H_MAX = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX = 10'(V_TOTAL - 1);

    logic [1:0] speed_q;
    logic       pause_q;
    logic [4:0] frm_cnt;
    logic [4:0] per_q;
    logic [4:0] per_new;
    logic       tick_hit;

    vga_pix_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .pix_tick (pix_tick)
    );

    assign line_end  = pix_tick && (h_count == H_MAX);
    assign frame_end = line_end && (v_count == V_MAX);

    assign per_q    = speed_period(speed_q);
    assign per_new  = speed_period(speed_sel);
    // >= rather than == so a count stranded above a shorter new period
    // still fires on the following frame instead of wrapping 5 bits.
    assign tick_hit = (frm_cnt >= 5'(per_q - 5'd1));

    assign game_tick = frame_end && !pause_q && tick_hit;

    // Horizontal pixel counter, advances once per pixel period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_count <= '0;
        end else if (pix_tick) begin
            if (h_count == H_MAX) begin
                h_count <= '0;
            end else begin
                h_count <= h_count + 10'd1;
            end
        end
    end

    // Vertical line counter, advances at the end of each line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_count <= '0;
        end else if (line_end) begin
            if (v_count == V_MAX) begin
                v_count <= '0;
            end else begin
                v_count <= v_count + 10'd1;
            end
        end
    end

    // Pause is sampled so it never reaches game_tick combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pause_q <= 1'b0;
        end else begin
            pause_q <= pause;
        end
    end

    // Speed select only changes at frame boundaries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            speed_q <= 2'b00;
        end else if (frame_end) begin
            speed_q <= speed_sel;
        end
    end

    // Frame counter: wraps on a tick, clears if the new period is shorter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frm_cnt <= '0;
        end else if (frame_end && !pause_q) begin
            if (tick_hit) begin
                frm_cnt <= '0;
            end else if (per_new <= frm_cnt) begin
                frm_cnt <= '0;
            end else begin
                frm_cnt <= frm_cnt + 5'd1;
            end
        end
    end

endmodule
